// File: rtl/gcd_pkg.sv
// Shared types and constants for the streaming binary-GCD block.
// Holds the FSM encoding and the STRIP+REDUCE cycle bound.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STRIP  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Worst-case cycles spent in STRIP plus REDUCE for a width-bit operand pair.
    function automatic int step_bound(input int width);
        return 4 * width + 2;
    endfunction

endpackage

// File: rtl/gcd_stream_if.sv
// Operand/result handshake bundle for gcd_stream.
// The master side is the producer/consumer; the slave side is the GCD engine.
interface gcd_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(4 * WIDTH + 4)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] steps;
    logic             busy;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, res, steps, busy
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, res, steps, busy
    );
endinterface

// File: rtl/gcd_step.sv
// One Stein reduction step: combinational next a/b/k for the current state.
// Latency 0 (pure combinational); no handshake of its own.
module gcd_step
    import gcd_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int K_W   = $clog2(WIDTH)
) (
    input  state_t           state,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [K_W-1:0]   k,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic [K_W-1:0]   k_nxt,
    output logic             strip_end,
    output logic             red_done,
    output logic [WIDTH-1:0] gcd_val
);

    always_comb begin
        a_nxt     = a;
        b_nxt     = b;
        k_nxt     = k;
        strip_end = 1'b0;
        red_done  = 1'b0;
        // Shared factor of two is restored only once a and b meet.
        gcd_val   = a << k;
        case (state)
            STRIP: begin
                if (!a[0] && !b[0]) begin
                    a_nxt = a >> 1;
                    b_nxt = b >> 1;
                    k_nxt = k + K_W'(1);
                end else begin
                    strip_end = 1'b1;
                end
            end
            REDUCE: begin
                if (!a[0]) begin
                    a_nxt = a >> 1;
                end else if (!b[0]) begin
                    b_nxt = b >> 1;
                end else if (a == b) begin
                    red_done = 1'b1;
                end else if (a > b) begin
                    a_nxt = a - b;
                end else begin
                    b_nxt = b - a;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gcd_stream.sv
// Streaming binary GCD: accepts x/y on a ready/valid port, returns gcd and cycle count.
// Latency 1 + STRIP/REDUCE cycles (<= 4*WIDTH+2); in_ready only in IDLE, result held until out_ready.
module gcd_stream
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(4 * WIDTH + 4)
) (
    input  logic          clk,
    input  logic          reset,
    gcd_stream_if.slave   io
);

    localparam int K_W   = $clog2(WIDTH);
    localparam int BOUND = step_bound(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] steps_q, steps_d;

    logic [WIDTH-1:0] a_nxt, b_nxt, gcd_val;
    logic [K_W-1:0]   k_nxt;
    logic             strip_end, red_done;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .state     (state_q),
        .a         (a_q),
        .b         (b_q),
        .k         (k_q),
        .a_nxt     (a_nxt),
        .b_nxt     (b_nxt),
        .k_nxt     (k_nxt),
        .strip_end (strip_end),
        .red_done  (red_done),
        .gcd_val   (gcd_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            res_q   <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            res_q   <= res_d;
            steps_q <= steps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        res_d   = res_q;
        steps_d = steps_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.x;
                    b_d     = io.y;
                    k_d     = '0;
                    steps_d = '0;
                    // A zero operand short-circuits: gcd(0, n) = n.
                    if (io.x == '0 || io.y == '0) begin
                        res_d   = io.x | io.y;
                        state_d = DONE;
                    end else begin
                        state_d = STRIP;
                    end
                end
            end
            STRIP: begin
                a_d     = a_nxt;
                b_d     = b_nxt;
                k_d     = k_nxt;
                steps_d = steps_q + CNT_W'(1);
                if (strip_end) state_d = REDUCE;
            end
            REDUCE: begin
                a_d     = a_nxt;
                b_d     = b_nxt;
                steps_d = steps_q + CNT_W'(1);
                if (red_done) begin
                    res_d   = gcd_val;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q == STRIP) || (state_q == REDUCE);
    assign io.res       = res_q;
    assign io.steps     = steps_q;

    a_step_bound: assert property (@(posedge clk) disable iff (reset)
        io.busy |-> (int'(steps_q) < BOUND));

endmodule

// File: tb/tb_gcd_stream.sv
// Scoreboarded bench for gcd_stream at WIDTH=8 and WIDTH=16.
module tb_gcd_stream;
    import gcd_pkg::*;

    typedef struct {
        logic [15:0] res;
        int          steps_exact;   // -1: only the cycle bound is checked
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gcd_stream_if #(.WIDTH(8))  if8  ();
    gcd_stream_if #(.WIDTH(16)) if16 ();

    gcd_stream #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .io(if8));
    gcd_stream #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .io(if16));

    int errors = 0;
    int checks = 0;
    int n_res8 = 0;
    int n_res16 = 0;
    exp_t exp8[$];
    exp_t exp16[$];
    exp_t m8, m16;

    function automatic logic [63:0] ref_gcd(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(negedge clk) begin
        if (!reset && if8.out_valid && if8.out_ready) begin
            checks++;
            if (exp8.size() == 0) begin
                errors++;
                $display("FAIL res8_unexpected got res=%0d, required no result", if8.res);
            end else begin
                m8 = exp8.pop_front();
                n_res8++;
                if (if8.res !== m8.res[7:0]) begin
                    errors++;
                    $display("FAIL res8 got %0d required %0d", if8.res, m8.res);
                end
                checks++;
                if (m8.steps_exact >= 0) begin
                    if (int'(if8.steps) != m8.steps_exact) begin
                        errors++;
                        $display("FAIL steps8 got %0d required %0d", if8.steps, m8.steps_exact);
                    end
                end else if (int'(if8.steps) > step_bound(8)) begin
                    errors++;
                    $display("FAIL steps8_bound got %0d required <= %0d", if8.steps, step_bound(8));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && if16.out_valid && if16.out_ready) begin
            checks++;
            if (exp16.size() == 0) begin
                errors++;
                $display("FAIL res16_unexpected got res=%0d, required no result", if16.res);
            end else begin
                m16 = exp16.pop_front();
                n_res16++;
                if (if16.res !== m16.res) begin
                    errors++;
                    $display("FAIL res16 got %0d required %0d", if16.res, m16.res);
                end
                checks++;
                if (int'(if16.steps) > step_bound(16)) begin
                    errors++;
                    $display("FAIL steps16_bound got %0d required <= %0d", if16.steps, step_bound(16));
                end
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input int st);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!if8.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if8.in_ready) begin
            errors++; checks++;
            $display("FAIL send8_timeout in_ready=%b required 1", if8.in_ready);
            return;
        end
        if8.x = a; if8.y = b; if8.in_valid = 1'b1;
        e.res = 16'(ref_gcd(64'(a), 64'(b)));
        e.steps_exact = st;
        exp8.push_back(e);
        @(posedge clk);
        #1 if8.in_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!if16.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if16.in_ready) begin
            errors++; checks++;
            $display("FAIL send16_timeout in_ready=%b required 1", if16.in_ready);
            return;
        end
        if16.x = a; if16.y = b; if16.in_valid = 1'b1;
        e.res = 16'(ref_gcd(64'(a), 64'(b)));
        e.steps_exact = -1;
        exp16.push_back(e);
        @(posedge clk);
        #1 if16.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp8.size() != 0 || exp16.size() != 0 || !if8.in_ready || !if16.in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp8.size() != 0 || exp16.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d/%0d required 0/0", name, exp8.size(), exp16.size());
        end
    endtask

    task automatic test_reset();
        #1;
        checks += 6;
        if (if8.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got %b required 1", if8.in_ready); end
        if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", if8.out_valid); end
        if (if8.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b required 0", if8.busy); end
        if (if8.res !== 8'd0)       begin errors++; $display("FAIL rst_res got %0d required 0", if8.res); end
        if (if8.steps !== 6'd0)     begin errors++; $display("FAIL rst_steps got %0d required 0", if8.steps); end
        if (if16.in_ready !== 1'b1) begin errors++; $display("FAIL rst16_in_ready got %b required 1", if16.in_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        int n = 0;
        if8.out_ready = 1'b1;
        send8(8'd86, 8'd84, 14);
        @(negedge clk);
        while (!if8.out_valid && n < 100) begin
            checks++;
            if (if8.in_ready !== 1'b0 || if8.busy !== 1'b1) begin
                errors++;
                $display("FAIL single_busy in_ready=%b busy=%b required 0/1", if8.in_ready, if8.busy);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (!if8.out_valid || if8.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_done out_valid=%b in_ready=%b required 1/0", if8.out_valid, if8.in_ready);
        end
        @(negedge clk);
        checks++;
        if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release in_ready=%b out_valid=%b required 1/0", if8.in_ready, if8.out_valid);
        end
    endtask

    task automatic test_sequence();
        int base;
        base = n_res8;
        send8(8'd90, 8'd23, -1);
        send8(8'd128, 8'd96, -1);
        send8(8'd255, 8'd255, -1);
        send8(8'd12, 8'd34, -1);
        drain("seq");
        checks++;
        if (n_res8 - base != 4) begin
            errors++;
            $display("FAIL seq_count got %0d required 4", n_res8 - base);
        end
    endtask

    task automatic test_zero();
        send8(8'd0, 8'd37, 0);
        @(negedge clk);
        checks++;
        if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL zero_latency1 out_valid=%b required 1", if8.out_valid); end
        send8(8'd0, 8'd0, 0);
        @(negedge clk);
        checks++;
        if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL zero_latency2 out_valid=%b required 1", if8.out_valid); end
        drain("zero");
    endtask

    task automatic test_hold();
        int n = 0;
        int base;
        if8.out_ready = 1'b0;
        send8(8'd10, 8'd30, -1);
        while (!if8.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        base = n_res8;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) begin if8.x = 8'd7; if8.y = 8'd14; if8.in_valid = 1'b1; end
            if (i == 6) if8.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (if8.out_valid !== 1'b1 || if8.res !== 8'd10 || if8.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d out_valid=%b res=%0d in_ready=%b required 1/10/0",
                         i, if8.out_valid, if8.res, if8.in_ready);
            end
        end
        if8.out_ready = 1'b1;
        drain("hold");
        repeat (10) @(negedge clk);
        checks++;
        if (n_res8 - base != 1 || if8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_ignored results=%0d out_valid=%b required 1/0", n_res8 - base, if8.out_valid);
        end
    endtask

    task automatic test_wide16();
        int base;
        base = n_res16;
        if16.out_ready = 1'b1;
        send16(16'd3858, 16'd3857);
        send16(16'd1020, 16'd1030);
        send16(16'd4567, 16'd3456);
        drain("wide16");
        checks++;
        if (n_res16 - base != 3) begin
            errors++;
            $display("FAIL wide16_count got %0d required 3", n_res16 - base);
        end
    endtask

    task automatic test_reset_mid();
        if8.out_ready = 1'b1;
        send8(8'd200, 8'd150, -1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks += 4;
        if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b required 0", if8.out_valid); end
        if (if8.in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready got %b required 1", if8.in_ready); end
        if (if8.res !== 8'd0)       begin errors++; $display("FAIL midrst_res got %0d required 0", if8.res); end
        if (if8.busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b required 0", if8.busy); end
        exp8.delete();
        @(negedge clk);
        reset = 1'b0;
        send8(8'd45, 8'd200, -1);
        drain("midrst");
    endtask

    initial begin
        if8.in_valid = 1'b0;  if8.x = '0;  if8.y = '0;  if8.out_ready = 1'b0;
        if16.in_valid = 1'b0; if16.x = '0; if16.y = '0; if16.out_ready = 1'b0;
        test_reset();
        test_single();
        test_sequence();
        test_zero();
        test_hold();
        test_wide16();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
